mat_seq_ctrl: RTL and testbench

- Sequencing controller for the 8-bit signed element ALU of the matrix coprocessor.
- On a start command it walks an NxN operation element by element. It reads operands from the A and B matrix memories, drives the ALU op and operands, and writes results to the C memory in row-major order.
- For matrix multiply it accumulates ALU products internally. It signals done when finished, or err for unsupported requests.

---
 rtl/mat_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mat_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_seq_ctrl.sv
// Sequencing controller for the 8-bit signed element ALU of the matrix coprocessor.
// Walks an NxN operation element by element: read A/B, drive the ALU, write C row-major.
module mat_seq_ctrl #(
  parameter int DW   = 8,
  parameter int MAXN = 5,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [2:0]    size,
  input  logic [DW-1:0] scalar,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          a_rd,
  output logic          b_rd,
  input  logic [DW-1:0] a_rdata,
  input  logic [DW-1:0] b_rdata,
  output logic [AW-1:0] c_addr,
  output logic          c_we,
  output logic [DW-1:0] c_wdata,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_res
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_EX, S_WR, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_SCL = 3'b011,
    OP_DET = 3'b100, OP_TRN = 3'b101, OP_OPP = 3'b110, OP_CLR = 3'b111
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [2:0]    n_q, n_d;
  logic [DW-1:0] scalar_q, scalar_d;
  logic [2:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;

  function automatic logic [AW-1:0] elem_addr(input logic [2:0] r, input logic [2:0] c);
    return AW'(r) * AW'(MAXN) + AW'(c);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      n_q      <= '0;
      scalar_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      n_q      <= n_d;
      scalar_q <= scalar_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    scalar_d = scalar_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    a_rd     = 1'b0;
    b_rd     = 1'b0;
    c_addr   = '0;
    c_we     = 1'b0;
    c_wdata  = '0;
    alu_op   = '0;
    alu_a    = '0;
    alu_b    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op_e'(op);
          n_d      = size;
          scalar_d = scalar;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          if (size == 3'd0 || size > 3'(MAXN) || op_e'(op) == OP_DET) state_d = S_ERR;
          else                                                         state_d = S_RD;
        end
      end

      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end

      S_RD: begin
        busy = 1'b1;
        a_rd = 1'b1;
        case (op_q)
          OP_TRN:  a_addr = elem_addr(j_q, i_q);
          OP_MUL:  a_addr = elem_addr(i_q, k_q);
          default: a_addr = elem_addr(i_q, j_q);
        endcase
        b_rd    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
        b_addr  = (op_q == OP_MUL) ? elem_addr(k_q, j_q) : elem_addr(i_q, j_q);
        state_d = S_EX;
      end

      S_EX: begin
        busy   = 1'b1;
        alu_op = op_q;
        alu_a  = a_rdata;
        case (op_q)
          OP_ADD, OP_SUB, OP_MUL: alu_b = b_rdata;
          OP_SCL:                 alu_b = scalar_q;
          OP_TRN:                 alu_b = DW'(1);
          OP_OPP:                 alu_b = '1;
          OP_CLR: begin
            alu_a = '0;
            alu_b = '0;
          end
          default:                alu_b = '0;
        endcase
        // Multiply loops RD/EX over k, summing products before a single write.
        if (op_q == OP_MUL) begin
          acc_d = acc_q + alu_res;
          if (k_q == n_q - 3'd1) begin
            state_d = S_WR;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_RD;
          end
        end else begin
          acc_d   = (op_q == OP_CLR) ? '0 : alu_res;
          state_d = S_WR;
        end
      end

      S_WR: begin
        busy    = 1'b1;
        c_we    = 1'b1;
        c_addr  = elem_addr(i_q, j_q);
        c_wdata = acc_q;
        k_d     = '0;
        acc_d   = '0;
        if (j_q < n_q - 3'd1) begin
          j_d     = j_q + 3'd1;
          state_d = S_RD;
        end else if (i_q < n_q - 3'd1) begin
          j_d     = '0;
          i_d     = i_q + 3'd1;
          state_d = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Bench for mat_seq_ctrl: behavioural A/B memories and ALU, a C-write scoreboard,
// a table of operations plus hand sequences for exact values, reset abort and ignored starts.
module tb_mat_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [2:0] size = '0;
  logic [7:0] scalar = '0;
  logic       busy, done, err;
  logic [4:0] a_addr, b_addr, c_addr;
  logic       a_rd, b_rd, c_we;
  logic [7:0] a_rdata = '0;
  logic [7:0] b_rdata = '0;
  logic [7:0] c_wdata;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_res;

  mat_seq_ctrl #(.DW(8), .MAXN(5), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .size(size), .scalar(scalar),
    .busy(busy), .done(done), .err(err),
    .a_addr(a_addr), .b_addr(b_addr), .a_rd(a_rd), .b_rd(b_rd),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  logic [7:0] amem [32];
  logic [7:0] bmem [32];

  always @(posedge clk) begin
    if (a_rd) a_rdata <= amem[a_addr];
    if (b_rd) b_rdata <= bmem[b_addr];
  end

  // Low 8 bits of a product are the same for signed and unsigned operands.
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = 8'(alu_a + alu_b);
      3'b001:  alu_res = 8'(alu_a - alu_b);
      3'b111:  alu_res = 8'd0;
      default: alu_res = 8'(alu_a * alu_b);
    endcase
  end

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sbq[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  a_cnt, b_cnt, wr_cnt, busy_cnt, done_cnt, err_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (a_rd) a_cnt++;
    if (b_rd) b_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (c_we) begin
      wr_cnt++;
      check("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("c_addr", 64'(c_addr), 64'(e.addr));
        check("c_wdata", 64'(c_wdata), 64'(e.data));
      end
    end
  end

  function automatic logic [7:0] model(input logic [2:0] mop, input int n, input int r,
                                       input int c, input logic [7:0] s);
    logic [7:0] acc;
    case (mop)
      3'b000:  return 8'(amem[r*5+c] + bmem[r*5+c]);
      3'b001:  return 8'(amem[r*5+c] - bmem[r*5+c]);
      3'b010: begin
        acc = '0;
        for (int k = 0; k < n; k++) acc = 8'(acc + 8'(amem[r*5+k] * bmem[k*5+c]));
        return acc;
      end
      3'b011:  return 8'(amem[r*5+c] * s);
      3'b101:  return amem[c*5+r];
      3'b110:  return 8'(8'd0 - amem[r*5+c]);
      default: return 8'd0;
    endcase
  endfunction

  task automatic clear_counts();
    a_cnt = 0; b_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic run_op(input logic [2:0] vop, input logic [2:0] vsize, input logic [7:0] vscalar,
                        input bit exp_err, input int exp_lat, input bit use_model, input int inject_at);
    int n, cyc, exp_a, exp_b;
    bit got, saw_err;
    n = int'(vsize);
    if (use_model && !exp_err)
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++)
          sbq.push_back('{addr: 5'(r*5+c), data: model(vop, n, r, c, vscalar)});
    exp_a = exp_err ? 0 : ((vop == 3'b010) ? n*n*n : n*n);
    exp_b = (vop <= 3'b010) ? exp_a : 0;
    @(posedge clk); #1;
    clear_counts();
    @(negedge clk);
    start = 1'b1; op = vop; size = vsize; scalar = vscalar;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); size = 3'($urandom); scalar = 8'($urandom);
    cyc = 0; got = 1'b0; saw_err = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_at);
      if (done || err) begin
        got = 1'b1;
        saw_err = err;
      end
    end
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("finished", 64'(got), 64'd1);
    check("latency", 64'(cyc), 64'(exp_lat));
    check("err_kind", 64'(saw_err), 64'(exp_err));
    check("done_count", 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
    check("err_count", 64'(err_cnt), exp_err ? 64'd1 : 64'd0);
    check("busy_cycles", 64'(busy_cnt), exp_err ? 64'd0 : 64'(exp_lat - 1));
    check("a_rd_count", 64'(a_cnt), 64'(exp_a));
    check("b_rd_count", 64'(b_cnt), 64'(exp_b));
    check("write_count", 64'(wr_cnt), exp_err ? 64'd0 : 64'(n*n));
    check("sb_drained", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] size;
    logic [7:0] scalar;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [63:0] out_vec();
    return {busy, done, err, a_rd, b_rd, c_we, a_addr, b_addr, c_addr, c_wdata,
            alu_op, alu_a, alu_b};
  endfunction

  task automatic load_2x2(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    amem[0] = a0; amem[1] = a1; amem[5] = a2; amem[6] = a3;
    bmem[0] = b0; bmem[1] = b1; bmem[5] = b2; bmem[6] = b3;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 3'd2, 8'd0,   1'b0, 13};
    vecs[1]  = '{3'b001, 3'd3, 8'd0,   1'b0, 28};
    vecs[2]  = '{3'b010, 3'd2, 8'd0,   1'b0, 21};
    vecs[3]  = '{3'b010, 3'd3, 8'd0,   1'b0, 64};
    vecs[4]  = '{3'b011, 3'd1, 8'd3,   1'b0, 4};
    vecs[5]  = '{3'b011, 3'd4, 8'hF9,  1'b0, 49};
    vecs[6]  = '{3'b101, 3'd3, 8'd0,   1'b0, 28};
    vecs[7]  = '{3'b110, 3'd4, 8'd0,   1'b0, 49};
    vecs[8]  = '{3'b111, 3'd5, 8'd0,   1'b0, 76};
    vecs[9]  = '{3'b010, 3'd5, 8'd0,   1'b0, 276};
    vecs[10] = '{3'b000, 3'd5, 8'd0,   1'b0, 76};
    vecs[11] = '{3'b000, 3'd6, 8'd0,   1'b1, 1};
    vecs[12] = '{3'b001, 3'd0, 8'd0,   1'b1, 1};
    vecs[13] = '{3'b100, 3'd2, 8'd0,   1'b1, 1};
    vecs[14] = '{3'b010, 3'd7, 8'd0,   1'b1, 1};
    for (int a = 0; a < 32; a++) begin
      amem[a] = '0;
      bmem[a] = '0;
    end
    clear_counts();

    #3;
    check("reset_outputs", out_vec(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_outputs", out_vec(), 64'd0);

    // Add N=2 with a start pulse injected while busy
    load_2x2(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40);
    sbq.push_back('{5'd0, 8'd11}); sbq.push_back('{5'd1, 8'd22});
    sbq.push_back('{5'd5, 8'd33}); sbq.push_back('{5'd6, 8'd44});
    run_op(3'b000, 3'd2, 8'd0, 1'b0, 13, 1'b0, 5);

    // Mult N=2, with a start pulse during DONE
    load_2x2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    sbq.push_back('{5'd0, 8'd19}); sbq.push_back('{5'd1, 8'd22});
    sbq.push_back('{5'd5, 8'd43}); sbq.push_back('{5'd6, 8'd50});
    run_op(3'b010, 3'd2, 8'd0, 1'b0, 21, 1'b0, 21);

    // Transpose N=3, A = 1..9 row-major
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) amem[r*5+c] = 8'(r*3 + c + 1);
    sbq.push_back('{5'd0, 8'd1});  sbq.push_back('{5'd1, 8'd4});  sbq.push_back('{5'd2, 8'd7});
    sbq.push_back('{5'd5, 8'd2});  sbq.push_back('{5'd6, 8'd5});  sbq.push_back('{5'd7, 8'd8});
    sbq.push_back('{5'd10, 8'd3}); sbq.push_back('{5'd11, 8'd6}); sbq.push_back('{5'd12, 8'd9});
    run_op(3'b101, 3'd3, 8'd0, 1'b0, 28, 1'b0, 0);

    // Wrap-around cases, N=1
    amem[0] = 8'd100; bmem[0] = 8'd100;
    sbq.push_back('{5'd0, 8'hC8});
    run_op(3'b000, 3'd1, 8'd0, 1'b0, 4, 1'b0, 0);
    amem[0] = 8'h80;
    sbq.push_back('{5'd0, 8'h80});
    run_op(3'b110, 3'd1, 8'd0, 1'b0, 4, 1'b0, 0);
    amem[0] = 8'd50;
    sbq.push_back('{5'd0, 8'h96});
    run_op(3'b011, 3'd1, 8'd3, 1'b0, 4, 1'b0, 0);

    // Rejected request with a start pulse during ERR
    run_op(3'b000, 3'd6, 8'd0, 1'b1, 1, 1'b0, 1);

    // Reset during the third element (EX cycle) of an add, N=2
    load_2x2(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40);
    sbq.push_back('{5'd0, 8'd11}); sbq.push_back('{5'd1, 8'd22});
    @(posedge clk); #1;
    clear_counts();
    @(negedge clk);
    start = 1'b1; op = 3'b000; size = 3'd2; scalar = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", out_vec(), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("abort_writes", 64'(wr_cnt), 64'd2);
    check("abort_sb_drained", 64'(sbq.size()), 64'd0);
    check("abort_idle", out_vec(), 64'd0);
    sbq.delete();

    for (int v = 0; v < 15; v++) begin
      for (int a = 0; a < 32; a++) begin
        amem[a] = 8'($urandom);
        bmem[a] = 8'($urandom);
      end
      run_op(vecs[v].op, vecs[v].size, vecs[v].scalar, vecs[v].exp_err, vecs[v].exp_lat, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
